// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: definitions shared by the memory-port arbiter and its sub-blocks.
//   state_t              arbiter FSM encoding (IDLE / BUSY / DONE)
//   ADDR_W_DEF, LINE_W_DEF  default address and cache-line widths
//   RW_READ, RW_WRITE    encoding of the request direction bit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches req upward starting at (last+1) mod N, wrapping around, and
// returns the index of the first set bit.
// Ports:
//   req    in  N      request vector
//   last   in  IDX_W  index granted most recently
//   grant  out IDX_W  selected index (0 when any=0)
//   any    out 1      at least one request is pending
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        cand  = '0;
        // Offsets 1..N visit every client once, ending on 'last' itself,
        // so a lone requester that was also the last grantee is still served.
        for (int i = 1; i <= N; i++) begin
            idx = int'(last) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IDX_W'(idx);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory line port between NUM_REQ
// cache controllers. Requests are granted one at a time in round-robin
// order, forwarded to memory, and completed with a one-cycle req_ready.
//
// Handshakes: a client raises req_valid[i] with rw/addr/wdata stable and
// holds it until its one-cycle req_ready[i] pulse; the arbiter holds
// arb2mem_valid until the single-cycle mem2arb_ready, which it only
// honours while BUSY.
//
// Ports:
//   clk            in   1               rising-edge clock
//   r              in   1               asynchronous active-high reset
//   req_valid      in   NUM_REQ         per-client request
//   req_rw         in   NUM_REQ         per-client direction (1 = write)
//   req_addr       in   NUM_REQ*ADDR_W  flattened, client i at [i*ADDR_W +: ADDR_W]
//   req_wdata      in   NUM_REQ*LINE_W  flattened write lines
//   req_ready      out  NUM_REQ         one-hot completion pulse
//   req_rdata      out  LINE_W          read line, qualified by req_ready
//   arb2mem_rw     out  1               memory direction
//   arb2mem_valid  out  1               memory request
//   arb2mem_addr   out  ADDR_W          memory address
//   arb2mem_data   out  LINE_W          memory write line
//   mem2arb_ready  in   1               memory completion
//   mem2arb_data   in   LINE_W          memory read line
//   req_err        out  1               (MEM_ARB_TIMEOUT_EN only) timeout flag
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, a BUSY
// transaction that memory has not answered after TIMEOUT_CYCLES cycles is
// completed with req_ready and req_err pulsing together.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int LINE_W         = LINE_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [LINE_W-1:0]          req_rdata,
    output logic                       arb2mem_rw,
    output logic                       arb2mem_valid,
    output logic [ADDR_W-1:0]          arb2mem_addr,
    output logic [LINE_W-1:0]          arb2mem_data,
    input  logic                       mem2arb_ready,
    input  logic [LINE_W-1:0]          mem2arb_data
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                       req_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mem_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, last_q, pick_idx;
    logic               pick_any;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic               busy_end;
    logic               grant_now;

    // Unpacked views of the flattened client buses.
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [LINE_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*LINE_W +: LINE_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign grant_now = (state_q == IDLE) && pick_any;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_hit;

    // A memory answer in the final allowed cycle wins over the timeout.
    assign timeout_hit = (state_q == BUSY) && !mem2arb_ready &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy_end    = mem2arb_ready || timeout_hit;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (grant_now) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
            err_q <= timeout_hit;
        end
    end

    assign req_err = (state_q == DONE) && err_q;
`else
    assign busy_end = mem2arb_ready;
`endif

    // State register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (busy_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant/request latches and read-data capture. Everything the memory
    // sees comes from these registers, so client-side changes after the
    // grant cannot disturb the transaction in flight.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_now) begin
                grant_q <= pick_idx;
                rw_q    <= req_rw[pick_idx];
                addr_q  <= addr_arr[pick_idx];
                wdata_q <= wdata_arr[pick_idx];
            end
            if ((state_q == BUSY) && mem2arb_ready && (rw_q == RW_READ)) begin
                rdata_q <= mem2arb_data;
            end
            if (state_q == DONE) begin
                last_q <= grant_q;
            end
        end
    end

    // Outputs. arb2mem_valid decodes straight from the state register so
    // an asynchronous reset drops it immediately.
    always_comb begin
        req_ready = '0;
        if (state_q == DONE) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign arb2mem_valid = (state_q == BUSY);
    assign arb2mem_rw    = rw_q;
    assign arb2mem_addr  = addr_q;
    assign arb2mem_data  = wdata_q;
    assign req_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table-driven bench for mem_port_arbiter
// (NUM_REQ=2, ADDR_W=32, LINE_W=128, TIMEOUT_CYCLES=8).
// Inputs are driven on the falling edge; outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int LW = 128;

    logic              clk = 1'b0;
    logic              r   = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_rw    = '0;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*LW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [LW-1:0]     req_rdata;
    logic              arb2mem_rw;
    logic              arb2mem_valid;
    logic [AW-1:0]     arb2mem_addr;
    logic [LW-1:0]     arb2mem_data;
    logic              mem2arb_ready = 1'b0;
    logic [LW-1:0]     mem2arb_data  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              req_err;
`endif

    mem_port_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .LINE_W         (LW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .r             (r),
        .req_valid     (req_valid),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .req_rdata     (req_rdata),
        .arb2mem_rw    (arb2mem_rw),
        .arb2mem_valid (arb2mem_valid),
        .arb2mem_addr  (arb2mem_addr),
        .arb2mem_data  (arb2mem_data),
        .mem2arb_ready (mem2arb_ready),
        .mem2arb_data  (mem2arb_data)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .req_err       (req_err)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int             n_cmp  = 0;
    int             n_fail = 0;
    logic [NR-1:0]  exp_q[$];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        r             = 1'b1;
        req_valid     = '0;
        mem2arb_ready = 1'b0;
        mem2arb_data  = '0;
        repeat (cycles) @(negedge clk);
        r = 1'b0;
    endtask

    task automatic drive_req(input int c, input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d);
        req_valid[c]            = 1'b1;
        req_rw[c]               = rw;
        req_addr[c*AW +: AW]    = a;
        req_wdata[c*LW +: LW]   = d;
    endtask

    // Advance to the first falling edge where arb2mem_valid is high.
    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arb2mem_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_busy: arb2mem_valid not seen within 20 cycles");
        end
    endtask

    typedef struct {
        int            client;
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] mdata;
        int            delay;      // BUSY cycles including the answering one
        logic [NR-1:0] exp_ready;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit ok;
        @(negedge clk);
        drive_req(v.client, v.rw, v.addr, v.wdata);
        wait_busy(ok);
        if (ok) begin
            check("mem_addr", arb2mem_addr, v.addr);
            check("mem_rw", arb2mem_rw, v.rw);
            if (v.rw) check("mem_wdata", arb2mem_data, v.wdata);
            // Client changes its address mid-transaction; must not leak.
            req_addr[v.client*AW +: AW] = ~v.addr;
            for (int i = 1; i < v.delay; i++) begin
                @(negedge clk);
                check("hold_valid", arb2mem_valid, 1'b1);
                check("no_early_ready", req_ready, '0);
            end
            mem2arb_ready = 1'b1;
            mem2arb_data  = v.mdata;
            @(negedge clk);
            mem2arb_ready = 1'b0;
            mem2arb_data  = '0;
            check("ready", req_ready, v.exp_ready);
            check("rdata", req_rdata, v.exp_rdata);
            check("valid_drop", arb2mem_valid, 1'b0);
            check("addr_stable", arb2mem_addr, v.addr);
            req_valid[v.client] = 1'b0;
            @(negedge clk);
            check("ready_one_cycle", req_ready, '0);
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t          vecs[5];
    vec_t          extra;
    logic [LW-1:0] d_dead, d_face, d_mix;
    logic [NR-1:0] exp_g;
    int            gi;
    int            busy_cycles;
    bit            ok;

    initial begin
        d_dead = {4{32'hDEADBEEF}};
        d_face = {4{32'hFEEDFACE}};
        d_mix  = {32'h01234567, 32'h89ABCDEF, 32'h00000000, 32'hFFFFFFFF};

        vecs[0] = '{0, 1'b0, 32'h0000_1234, {4{32'h11111111}}, d_dead, 2, 2'b01, d_dead};
        vecs[1] = '{1, 1'b1, 32'h0000_5678, d_face, {4{32'h55555555}}, 1, 2'b10, d_dead};
        vecs[2] = '{1, 1'b0, 32'h0000_00F0, '0, d_mix, 1, 2'b10, d_mix};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFF0, {4{32'hAAAAAAAA}}, {4{32'h33333333}}, 3, 2'b01, d_mix};
        vecs[4] = '{0, 1'b0, 32'hFFFF_FFFF, '0, '0, 1, 2'b01, '0};

        // 1. Reset then idle.
        do_reset(2);
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_rdata", req_rdata, '0);
        check("rst_valid", arb2mem_valid, 1'b0);
        check("rst_rw", arb2mem_rw, 1'b0);
        check("rst_addr", arb2mem_addr, '0);
        check("rst_data", arb2mem_data, '0);
`ifdef MEM_ARB_TIMEOUT_EN
        check("rst_err", req_err, 1'b0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_valid", arb2mem_valid, 1'b0);
        end

        // 2/3. Single reads and writes from the vector table.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // mem2arb_ready outside BUSY must be ignored (rdata is 0 from vecs[4]).
        @(negedge clk);
        mem2arb_ready = 1'b1;
        mem2arb_data  = {4{32'hFFFFFFFF}};
        @(negedge clk);
        mem2arb_ready = 1'b0;
        mem2arb_data  = '0;
        check("stray_rdata", req_rdata, '0);
        check("stray_ready", req_ready, '0);
        check("stray_valid", arb2mem_valid, 1'b0);

        // 4. Contention from a fresh reset: grants must alternate 0,1,0,1.
        do_reset(2);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        drive_req(0, 1'b0, 32'h0000_0100, '0);
        drive_req(1, 1'b0, 32'h0000_0200, '0);
        for (int k = 0; k < 4; k++) begin
            wait_busy(ok);
            if (!ok) break;
            exp_g = exp_q.pop_front();
            gi    = (exp_g == 2'b10) ? 1 : 0;
            check("cont_addr", arb2mem_addr, (gi == 1) ? 32'h0000_0200 : 32'h0000_0100);
            mem2arb_ready = 1'b1;
            mem2arb_data  = {4{32'(k + 1)}};
            @(negedge clk);
            mem2arb_ready = 1'b0;
            check("cont_ready", req_ready, exp_g);
            check("cont_onehot", $onehot(req_ready), 1'b1);
            check("cont_rdata", req_rdata, {4{32'(k + 1)}});
            req_valid[gi] = 1'b0;
            @(negedge clk);
            if (k < 3) req_valid[gi] = 1'b1;
            else       req_valid     = '0;
        end
        check("cont_queue_empty", exp_q.size(), 0);

        // 5. Reset mid-BUSY. Make client0 the last grantee first, so that
        // without the reset the rotation would favour client1.
        extra = '{0, 1'b0, 32'h0000_0040, '0, {4{32'h0BADF00D}}, 1, 2'b01, {4{32'h0BADF00D}}};
        run_vec(extra);
        @(negedge clk);
        drive_req(1, 1'b0, 32'h0000_0300, '0);
        wait_busy(ok);
        check("pre_rst_addr", arb2mem_addr, 32'h0000_0300);
        drive_req(0, 1'b0, 32'h0000_0400, '0);
        r = 1'b1;
        #1;
        check("async_valid_drop", arb2mem_valid, 1'b0);
        check("rst_no_ready", req_ready, '0);
        check("rst_rdata_clr", req_rdata, '0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_ready", req_ready, '0);
        end
        r = 1'b0;
        wait_busy(ok);
        check("post_rst_grant0", arb2mem_addr, 32'h0000_0400);
        mem2arb_ready = 1'b1;
        mem2arb_data  = d_dead;
        @(negedge clk);
        mem2arb_ready = 1'b0;
        check("post_rst_ready", req_ready, 2'b01);
        req_valid = '0;
        @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // 6. Timeout: memory never answers.
        do_reset(2);
        @(negedge clk);
        drive_req(0, 1'b0, 32'h0000_0500, '0);
        wait_busy(ok);
        busy_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!arb2mem_valid) break;
            busy_cycles++;
        end
        check("to_busy_cycles", busy_cycles, 8);
        check("to_ready", req_ready, 2'b01);
        check("to_err", req_err, 1'b1);
        check("to_rdata", req_rdata, '0);
        req_valid = '0;
        mem2arb_ready = 1'b1;
        mem2arb_data  = d_face;
        @(negedge clk);
        mem2arb_ready = 1'b0;
        check("late_rdata", req_rdata, '0);
        check("late_err", req_err, 1'b0);
        check("late_ready", req_ready, '0);
`endif

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing-memory line port between NUM_REQ cache controllers, e.g. I-cache and D-cache.
- Each client presents a cache2mem-style request. The arbiter grants one at a time in round-robin order and forwards it to memory.
- Memory read data is returned to the granted client, with a one-cycle ready pulse marking completion.
- Sits between the cache blocks and the memory model/controller.

Parameters:
- NUM_REQ, 2, number of requesting caches (2..8).
- ADDR_W, 32, address width.
- LINE_W, 128, cache line width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- r  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-client request. Held high, with rw/addr/wdata stable, until that client's req_ready pulse.
- req_rw  in  NUM_REQ  per-client direction: 1 = write line, 0 = read line.
- req_addr  in  NUM_REQ*ADDR_W  flattened; client i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*LINE_W  flattened write lines.
- req_ready  out  NUM_REQ  one-hot completion pulse, one cycle wide.
- req_rdata  out  LINE_W  read line, broadcast to all clients; qualified by req_ready.
- arb2mem_rw  out  1  memory direction.
- arb2mem_valid  out  1  memory request; held high until mem2arb_ready.
- arb2mem_addr  out  ADDR_W  memory address.
- arb2mem_data  out  LINE_W  memory write line.
- mem2arb_ready  in  1  memory completion; one cycle.
- mem2arb_data  in  LINE_W  memory read line; valid with mem2arb_ready.

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; req_rdata=0.
  - Last-grant pointer = NUM_REQ-1, so client 0 has first priority.
  - Reset asserted mid-transaction aborts immediately: arb2mem_valid drops asynchronously, no req_ready pulse is issued, and the client must reissue.
- FSM IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first requester found searching upward from (last+1) mod NUM_REQ, wrapping around.
  - Latch grant index, rw, addr and wdata into registers; go to BUSY.
  - With no requests, remain in IDLE.
- BUSY:
  - arb2mem_valid=1; arb2mem_* driven from the latched registers.
  - On mem2arb_ready: if the request is a read, capture mem2arb_data into req_rdata; go to DONE.
  - Otherwise remain in BUSY.
- DONE:
  - req_ready[grant]=1 for exactly one cycle; arb2mem_valid=0.
  - last = grant; go to IDLE.
- Latency: request sampled at edge k. The earliest req_ready is in cycle k+2, when memory answers in the first BUSY cycle.
- Back-to-back requests: a new grant is made in the IDLE cycle following DONE. Because the client must drop req_valid the cycle after its ready, it cannot be regranted spuriously.
- Fairness: if all clients request continuously, grants rotate 0,1,...,NUM_REQ-1,0. No client waits more than NUM_REQ-1 other transactions.
- Writes: req_rdata is unchanged after a write.
- mem2arb_ready outside BUSY is ignored.
- Requests are registered at the IDLE grant, so a client changing req_valid/rw/addr/wdata mid-transaction has no effect on the current transaction.
- A client's req_valid rising during another client's transaction is served by the rotation after DONE.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds port req_err (out, 1).
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without mem2arb_ready, go to DONE: req_ready[grant] and req_err pulse together, req_rdata is unchanged, and arb2mem_valid drops.
  - A late mem2arb_ready is then ignored.
- When undefined: no counter and no req_err port; BUSY waits indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - ADDR_W/LINE_W defaults;
  - the RW_READ/RW_WRITE constants.
- One natural sub-module, rr_pick: combinational round-robin selector (req vector, last index -> grant index, any). It is reused by future bus arbiters.

Test Plan:
1. Reset then idle: r=1 for 2 cycles, then 0 → all outputs 0 and arb2mem_valid stays 0 with no requests.
2. Single read: client0 reads addr 0x1234; memory returns 128'hDEADBEEF×4 after 2 BUSY cycles → arb2mem_addr=0x1234, rw=0; req_ready=2'b01 one cycle; req_rdata=DEADBEEF×4.
3. Single write: client1 writes 0x5678 with FEEDFACE×4 → arb2mem_rw=1, arb2mem_data=FEEDFACE×4; req_ready=2'b10; req_rdata unchanged.
4. Contention: both clients request reads simultaneously and re-request after each ready → grants go 0,1,0,1 and each req_ready is one-hot.
5. Reset mid-BUSY: assert r while arb2mem_valid=1 → arb2mem_valid falls before the next edge, no req_ready, and client0 is granted first after release.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory never answers → after 8 BUSY cycles, req_ready and req_err pulse together; a late mem2arb_ready is ignored.
